// File: rtl/coproc_xif_pipe.sv
// rtl/coproc_xif_pipe.sv - CV-X-IF coprocessor with in-order slot queue and result register
module coproc_xif_pipe #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] MAGIC      = 32'hDEADBEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]       issue_rs0_i,
  input  logic [XLEN-1:0]       issue_rs1_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]       result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o,
  output logic                  busy_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_FREE, S_ISSUED, S_COMMITTED, S_KILLED} slot_state_e;

  slot_state_e           state_q   [DEPTH];
  slot_state_e           state_eff [DEPTH];
  slot_state_e           state_d   [DEPTH];
  logic                  is_test_q [DEPTH];
  logic [2:0]            funct3_q  [DEPTH];
  logic [XLEN-1:0]       rs0_q     [DEPTH];
  logic [XLEN-1:0]       rs1_q     [DEPTH];
  logic [4:0]            rd_q      [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q      [DEPTH];
  logic [PW-1:0]         head_q, tail_q;
  logic [PW:0]           count_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       dec_test, dec_alu, dec_ok, full, push, commit_new;
  logic       head_kill, head_load, head_pop;
  logic       unused_instr;

  assign opcode       = issue_instr_i[6:0];
  assign funct3       = issue_instr_i[14:12];
  assign unused_instr = ^issue_instr_i[31:15];
  assign dec_test     = (opcode == 7'h0a);
  assign dec_alu      = (opcode == 7'h0b) && (funct3 <= 3'd4);
  assign dec_ok       = dec_test || dec_alu;
  assign full         = (count_q == (PW+1)'(DEPTH));
  assign push         = issue_valid_i && issue_ready_o && dec_ok;
  assign commit_new   = commit_valid_i && (commit_id_i == issue_id_i);

  function automatic logic [XLEN-1:0] exec_op(input logic is_test, input logic [2:0] f3,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [SW-1:0]   sh;
    r  = '0;
    sh = b[SW-1:0];
    if (is_test) begin
      r = XLEN'(MAGIC);
    end else begin
      case (f3)
        3'd0:    r = a + b;
        3'd1:    r = a ^ b;
        3'd2:    r = (a << sh) | (a >> (XLEN - sh));
        3'd3:    for (int i = 0; i < XLEN; i++) r = r + XLEN'(a[i]);
        default: r = (a < b) ? a : b;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= S_FREE;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
    end
  end

  // Commits are resolved before head inspection so a commit of the head yields a result next cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_eff[i] = state_q[i];
      if (commit_valid_i && state_q[i] == S_ISSUED && id_q[i] == commit_id_i)
        state_eff[i] = commit_kill_i ? S_KILLED : S_COMMITTED;
    end
    head_kill = (state_eff[head_q] == S_KILLED);
    head_load = (state_eff[head_q] == S_COMMITTED) && (!result_valid_o || result_ready_i);
    head_pop  = head_kill || head_load;
    for (int i = 0; i < DEPTH; i++) state_d[i] = state_eff[i];
    if (head_pop) state_d[head_q] = S_FREE;
    if (push) state_d[tail_q] = commit_new ? (commit_kill_i ? S_KILLED : S_COMMITTED) : S_ISSUED;
  end

  always_comb begin
    issue_ready_o     = !full && (dec_alu ? &issue_rs_valid_i : 1'b1);
    issue_accept_o    = issue_valid_i && dec_ok;
    issue_writeback_o = issue_valid_i && dec_ok;
    busy_o            = (count_q != '0) || result_valid_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (head_pop) head_q <= head_q + 1'b1;
      if (push) tail_q <= tail_q + 1'b1;
      case ({push, head_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      is_test_q[tail_q] <= dec_test;
      funct3_q[tail_q]  <= funct3;
      rs0_q[tail_q]     <= issue_rs0_i;
      rs1_q[tail_q]     <= issue_rs1_i;
      rd_q[tail_q]      <= issue_instr_i[11:7];
      id_q[tail_q]      <= issue_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
    end else if (head_load) begin
      result_valid_o <= 1'b1;
      result_id_o    <= id_q[head_q];
      result_data_o  <= exec_op(is_test_q[head_q], funct3_q[head_q], rs0_q[head_q], rs1_q[head_q]);
      result_rd_o    <= rd_q[head_q];
      result_we_o    <= (rd_q[head_q] != 5'd0);
    end else if (result_valid_o && result_ready_i) begin
      result_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_coproc_xif_pipe.sv
// tb/tb_coproc_xif_pipe.sv - directed and randomized bench for coproc_xif_pipe
module tb_coproc_xif_pipe;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i = '0;
  logic [3:0]  issue_id_i = '0;
  logic [31:0] issue_rs0_i = '0;
  logic [31:0] issue_rs1_i = '0;
  logic [1:0]  issue_rs_valid_i = 2'b11;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  coproc_xif_pipe dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
    .issue_id_i(issue_id_i), .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
    .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o), .commit_valid_i(commit_valid_i),
    .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i), .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          done;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  logic [15:0] pop_log = '0;
  bit          last_push = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit op_ok(input logic [31:0] ins);
    return (ins[6:0] == 7'h0a) || (ins[6:0] == 7'h0b && ins[14:12] <= 3'd4);
  endfunction

  function automatic logic [31:0] ref_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (ins[6:0] == 7'h0a) return 32'hDEADBEEF;
    case (ins[14:12])
      3'd0: return a + b;
      3'd1: return a ^ b;
      3'd2: begin
        r = a;
        for (int k = 0; k < int'(b[4:0]); k++) r = {r[30:0], r[31]};
        return r;
      end
      3'd3: return 32'($countones(a));
      default: return (a < b) ? a : b;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {17'd0, f3, rd, opc};
  endfunction

  // One clock: check the issue handshake, update the model, check any popped result, advance.
  task automatic step();
    #1;
    last_push = 1'b0;
    if (issue_valid_i) begin
      chk("accept", issue_accept_o, op_ok(issue_instr_i));
      chk("writeback", issue_writeback_o, op_ok(issue_instr_i));
      if (issue_ready_o && op_ok(issue_instr_i)) begin
        mq.push_back('{issue_id_i, ref_exec(issue_instr_i, issue_rs0_i, issue_rs1_i),
                       issue_instr_i[11:7], 1'b0, 1'b0});
        last_push = 1'b1;
      end
    end
    if (commit_valid_i)
      foreach (mq[i])
        if (!mq[i].done && mq[i].id == commit_id_i) begin
          mq[i].done = 1'b1;
          mq[i].kill = commit_kill_i;
        end
    if (result_valid_o && result_ready_i) begin
      while (mq.size() > 0 && mq[0].kill) void'(mq.pop_front());
      if (mq.size() == 0) chk("pending_for_result", 64'(mq.size()), 64'd1);
      else begin
        chk("res_id", result_id_o, mq[0].id);
        chk("res_data", result_data_o, mq[0].data);
        chk("res_rd", result_rd_o, mq[0].rd);
        chk("res_we", result_we_o, mq[0].rd != 5'd0);
        chk("res_after_commit", mq[0].done, 1'b1);
        pop_log = {pop_log[11:0], result_id_o};
        pops++;
        void'(mq.pop_front());
      end
    end
    @(posedge clk_i);
    #1;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [3:0] id, input logic [31:0] a, input logic [31:0] b);
    issue_instr_i = ins; issue_id_i = id; issue_rs0_i = a; issue_rs1_i = b;
    issue_rs_valid_i = 2'b11; issue_valid_i = 1'b1;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
  endtask

  task automatic run_one(input logic [31:0] ins, input logic [3:0] id, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    result_ready_i = 1'b0;
    issue(ins, id, a, b); step();
    commit(id, 1'b0); step();
    chk("one_valid", result_valid_o, 1'b1);
    chk("one_id", result_id_o, id);
    chk("one_data", result_data_o, exp);
    chk("one_rd", result_rd_o, ins[11:7]);
    chk("one_we", result_we_o, ins[11:7] != 5'd0);
    result_ready_i = 1'b1; step(); result_ready_i = 1'b0;
    chk("one_drained", result_valid_o, 1'b0);
  endtask

  initial begin
    int k, n;
    logic [3:0] next_id;
    logic [2:0] f3;
    logic [6:0] opc;
    logic [31:0] ins;
    int cand[$];

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", result_valid_o, 1'b0);
    chk("rst_data", result_data_o, 32'd0);
    chk("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    issue_instr_i = mk(3'd0, 5'd5, 7'h0a);
    #1;
    chk("idle_ready", issue_ready_o, 1'b1);
    chk("idle_accept", issue_accept_o, 1'b0);
    @(posedge clk_i); #1;

    run_one(mk(3'd0, 5'd5, 7'h0a), 4'd3, 32'h1234, 32'h5678, 32'hDEADBEEF);
    run_one(mk(3'd0, 5'd0, 7'h0b), 4'd7, 32'hFFFFFFFF, 32'd2, 32'd1);
    run_one(mk(3'd2, 5'd9, 7'h0b), 4'd8, 32'h80000001, 32'd1, 32'h00000003);
    run_one(mk(3'd3, 5'd10, 7'h0b), 4'd9, 32'h0000F0F0, 32'd0, 32'd8);
    run_one(mk(3'd4, 5'd11, 7'h0b), 4'd10, 32'd5, 32'd3, 32'd3);
    run_one(mk(3'd1, 5'd12, 7'h0b), 4'd11, 32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F);

    issue(mk(3'd7, 5'd4, 7'h0b), 4'd2, 32'd1, 32'd1);
    #1;
    chk("bad_f3_accept", issue_accept_o, 1'b0);
    chk("bad_f3_wb", issue_writeback_o, 1'b0);
    step(); step(); step();
    chk("bad_f3_busy", busy_o, 1'b0);
    chk("bad_f3_noresult", result_valid_o, 1'b0);

    issue(mk(3'd0, 5'd4, 7'h0b), 4'd2, 32'd1, 32'd1);
    issue_rs_valid_i = 2'b01;
    #1;
    chk("rs_gate_ready", issue_ready_o, 1'b0);
    step();
    issue_rs_valid_i = 2'b11;

    for (int i = 1; i <= 4; i++) begin
      issue(mk(3'd0, 5'(i), 7'h0a), 4'(i), 32'd0, 32'd0);
      step();
    end
    issue(mk(3'd0, 5'd5, 7'h0a), 4'd5, 32'd0, 32'd0);
    #1;
    chk("full_ready", issue_ready_o, 1'b0);
    step();
    pop_log = '0; pops = 0; result_ready_i = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      commit(4'(i), 1'b0);
      step();
    end
    repeat (6) step();
    chk("order_ids", pop_log, 16'h1234);
    chk("order_pops", pops, 4);

    pop_log = '0; result_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      issue(mk(3'd0, 5'(i), 7'h0a), 4'(i), 32'd0, 32'd0);
      step();
    end
    commit(4'd2, 1'b1); step();
    commit(4'd1, 1'b0); step();
    commit(4'd3, 1'b0); step();
    step(); step();
    chk("hold_valid", result_valid_o, 1'b1);
    chk("hold_id", result_id_o, 4'd1);
    chk("hold_data", result_data_o, 32'hDEADBEEF);
    result_ready_i = 1'b1;
    repeat (6) step();
    chk("kill_ids", pop_log, 16'h0013);

    result_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue(mk(3'd0, 5'(i), 7'h0a), 4'(i), 32'd0, 32'd0);
      step();
    end
    commit(4'd1, 1'b0); step();
    chk("pre_rst_valid", result_valid_o, 1'b1);
    rst_ni = 1'b0;
    issue_instr_i = mk(3'd0, 5'd5, 7'h0a);
    #1;
    chk("arst_valid", result_valid_o, 1'b0);
    chk("arst_id", result_id_o, 4'd0);
    chk("arst_data", result_data_o, 32'd0);
    chk("arst_rd", result_rd_o, 5'd0);
    chk("arst_we", result_we_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_ready", issue_ready_o, 1'b1);
    mq.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    step();

    next_id = 4'd0;
    for (int c = 0; c < 400; c++) begin
      result_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 7);
        opc = (k == 7) ? 7'h33 : ((k == 0) ? 7'h0a : 7'h0b);
        f3 = (k >= 1 && k <= 5) ? 3'(k - 1) : ((k == 6) ? 3'($urandom_range(5, 7)) : 3'($urandom));
        ins = $urandom;
        ins[14:0] = {f3, 5'($urandom), opc};
        issue(ins, next_id, $urandom, $urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        cand.delete();
        foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
        if (cand.size() > 0) commit(mq[cand[$urandom_range(0, cand.size() - 1)]].id, $urandom_range(0, 3) == 0);
      end
      step();
      if (last_push) next_id = next_id + 4'd1;
    end

    result_ready_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      foreach (mq[i]) if (!mq[i].done && !commit_valid_i) commit(mq[i].id, 1'b0);
      step();
    end
    n = 0;
    foreach (mq[i]) if (!mq[i].kill) n++;
    chk("drain_left", n, 0);
    chk("drain_busy", busy_o, 1'b0);
    chk("drain_valid", result_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
